// File: rtl/ram_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : ram_arbiter
// Purpose  : Shares one synchronous single-port RAM between the 6502 core and
//            N read-only clients, stalling the CPU at opcode fetch via RDY.
// Revision : 1.0
// ============================================================================
module ram_arbiter #(
    parameter int ADDR_WIDTH = 11,
    parameter int DATA_WIDTH = 8,
    parameter int N_CLIENTS  = 2,
    parameter int RR_MODE    = 1,
    parameter int MAX_BURST  = 16
) (
    input  logic                            clk,
    input  logic                            reset_n,
    input  logic [ADDR_WIDTH-1:0]           cpu_addr,
    input  logic [DATA_WIDTH-1:0]           cpu_wdata,
    input  logic                            cpu_we,
    input  logic                            cpu_sync,
    output logic                            cpu_rdy,
    input  logic [N_CLIENTS-1:0]            cli_req,
    input  logic [N_CLIENTS*ADDR_WIDTH-1:0] cli_addr,
    output logic [N_CLIENTS-1:0]            cli_gnt,
    output logic [N_CLIENTS-1:0]            cli_valid,
    output logic [DATA_WIDTH-1:0]           rdata,
    output logic [ADDR_WIDTH-1:0]           ram_addr,
    output logic                            ram_we,
    output logic [DATA_WIDTH-1:0]           ram_wdata,
    input  logic [DATA_WIDTH-1:0]           ram_rdata
);

    localparam int PTR_W = (N_CLIENTS > 1) ? $clog2(N_CLIENTS) : 1;

    typedef enum logic [1:0] {
        RST_WAIT = 2'd0,
        CPU_RUN  = 2'd1,
        CLIENT   = 2'd2
    } state_t;

    state_t                 state_q, state_d;
    logic                   cpu_rdy_q, cpu_rdy_d;
    logic [N_CLIENTS-1:0]   valid_q, valid_d;
    logic [7:0]             count_q, count_d;
    logic                   hold_q, hold_d;
    logic [PTR_W-1:0]       rr_q, rr_d;

    logic [PTR_W-1:0]       sel;
    logic                   sel_found;
    logic [N_CLIENTS-1:0]   sel_oh;
    logic [ADDR_WIDTH-1:0]  sel_addr;
    logic [PTR_W-1:0]       sel_next;
    logic [7:0]             count_inc;
    int                     idx;

    // Scan starting at the rr pointer (or at 0 in fixed-priority mode).
    always_comb begin
        sel       = '0;
        sel_found = 1'b0;
        idx       = 0;
        for (int i = 0; i < N_CLIENTS; i++) begin
            if (RR_MODE != 0) begin
                idx = (int'(rr_q) + i) % N_CLIENTS;
            end else begin
                idx = i;
            end
            if (!sel_found && cli_req[idx]) begin
                sel_found = 1'b1;
                sel       = PTR_W'(idx);
            end
        end
    end

    always_comb begin
        sel_oh   = '0;
        sel_addr = '0;
        for (int i = 0; i < N_CLIENTS; i++) begin
            if (sel == PTR_W'(i)) begin
                sel_oh[i] = sel_found;
                sel_addr  = cli_addr[i*ADDR_WIDTH +: ADDR_WIDTH];
            end
        end
        sel_next  = (sel == PTR_W'(N_CLIENTS - 1)) ? '0 : sel + 1'b1;
        count_inc = count_q + 8'd1;
    end

    always_comb begin
        state_d   = state_q;
        cpu_rdy_d = cpu_rdy_q;
        valid_d   = '0;
        count_d   = count_q;
        hold_d    = hold_q;
        rr_d      = rr_q;
        cli_gnt   = '0;
        ram_addr  = cpu_addr;
        ram_wdata = cpu_wdata;
        ram_we    = 1'b0;

        case (state_q)
            RST_WAIT: begin
                state_d   = CPU_RUN;
                cpu_rdy_d = 1'b1;
            end
            CPU_RUN: begin
                ram_we = cpu_we & cpu_rdy_q;
                if (cpu_rdy_q && !cpu_sync) begin
                    hold_d = 1'b0;
                end
                // The fetch cycle itself still completes for the CPU.
                if ((|cli_req) && cpu_sync && cpu_rdy_q && !hold_q) begin
                    state_d   = CLIENT;
                    cpu_rdy_d = 1'b0;
                    count_d   = '0;
                end
            end
            CLIENT: begin
                if (sel_found) begin
                    cli_gnt  = sel_oh;
                    ram_addr = sel_addr;
                    valid_d  = sel_oh;
                    rr_d     = sel_next;
                    count_d  = count_inc;
                    if (count_inc == 8'(MAX_BURST)) begin
                        state_d   = CPU_RUN;
                        cpu_rdy_d = 1'b1;
                        hold_d    = 1'b1;
                    end
                end else begin
                    state_d   = CPU_RUN;
                    cpu_rdy_d = 1'b1;
                    hold_d    = 1'b1;
                end
            end
            default: begin
                state_d = RST_WAIT;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= RST_WAIT;
            cpu_rdy_q <= 1'b0;
            valid_q   <= '0;
            count_q   <= '0;
            hold_q    <= 1'b0;
            rr_q      <= '0;
        end else begin
            state_q   <= state_d;
            cpu_rdy_q <= cpu_rdy_d;
            valid_q   <= valid_d;
            count_q   <= count_d;
            hold_q    <= hold_d;
            rr_q      <= rr_d;
        end
    end

    assign cpu_rdy   = cpu_rdy_q;
    assign cli_valid = valid_q;
    assign rdata     = ram_rdata;

endmodule
`default_nettype wire

// File: tb/tb_ram_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_ram_arbiter
// Purpose  : Self-checking bench; round-robin and fixed-priority arbiters
//            driven in lockstep, each with its own RAM model.
// Revision : 1.0
// ============================================================================
module tb_ram_arbiter;

    localparam int AW = 11;
    localparam int DW = 8;
    localparam int NC = 3;
    localparam int MB = 4;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic              reset_n;
    logic [AW-1:0]     cpu_addr;
    logic [DW-1:0]     cpu_wdata;
    logic              cpu_we, cpu_sync;
    logic [NC-1:0]     cli_req;
    logic [NC*AW-1:0]  cli_addr;

    logic              a_rdy, b_rdy;
    logic [NC-1:0]     a_gnt, b_gnt, a_val, b_val;
    logic [DW-1:0]     a_rdata, b_rdata, a_ram_wdata, b_ram_wdata;
    logic [DW-1:0]     a_ram_rdata, b_ram_rdata;
    logic [AW-1:0]     a_ram_addr, b_ram_addr;
    logic              a_ram_we, b_ram_we;

    logic [DW-1:0]     mem_a [2**AW];
    logic [DW-1:0]     mem_b [2**AW];

    ram_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .N_CLIENTS(NC), .RR_MODE(1), .MAX_BURST(MB)) u_rr (
        .clk(clk), .reset_n(reset_n), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
        .cpu_we(cpu_we), .cpu_sync(cpu_sync), .cpu_rdy(a_rdy), .cli_req(cli_req),
        .cli_addr(cli_addr), .cli_gnt(a_gnt), .cli_valid(a_val), .rdata(a_rdata),
        .ram_addr(a_ram_addr), .ram_we(a_ram_we), .ram_wdata(a_ram_wdata), .ram_rdata(a_ram_rdata)
    );

    ram_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .N_CLIENTS(NC), .RR_MODE(0), .MAX_BURST(MB)) u_fp (
        .clk(clk), .reset_n(reset_n), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
        .cpu_we(cpu_we), .cpu_sync(cpu_sync), .cpu_rdy(b_rdy), .cli_req(cli_req),
        .cli_addr(cli_addr), .cli_gnt(b_gnt), .cli_valid(b_val), .rdata(b_rdata),
        .ram_addr(b_ram_addr), .ram_we(b_ram_we), .ram_wdata(b_ram_wdata), .ram_rdata(b_ram_rdata)
    );

    always @(posedge clk) begin
        if (a_ram_we) mem_a[a_ram_addr] <= a_ram_wdata;
        if (b_ram_we) mem_b[b_ram_addr] <= b_ram_wdata;
        a_ram_rdata <= mem_a[a_ram_addr];
        b_ram_rdata <= mem_b[b_ram_addr];
    end

    function automatic logic [DW-1:0] fdat(input logic [AW-1:0] a);
        return a[7:0] ^ 8'hA5;
    endfunction

    function automatic logic [AW-1:0] caddr(input int i);
        return AW'(16 * (i + 1));
    endfunction

    function automatic logic [AW-1:0] addr_of(input logic [NC-1:0] oh);
        logic [AW-1:0] r;
        r = '0;
        for (int i = 0; i < NC; i++) if (oh[i]) r = caddr(i);
        return r;
    endfunction

    typedef struct {
        logic [NC-1:0] v;
        logic [DW-1:0] d;
    } sb_t;
    sb_t sbq[$];

    typedef struct {
        logic [NC-1:0] req;
        logic          sync;
        logic          we;
        logic [NC-1:0] ega;
        logic [NC-1:0] egb;
        logic          erdy;
        logic          ewe;
    } vec_t;
    vec_t tbl[13];

    int errors = 0;
    int checks = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // One call per cycle at the negedge; valid/rdata expectations ride the queue.
    task automatic check_cycle(input string name, input logic [NC-1:0] ega, input logic [NC-1:0] egb,
                               input logic erdy, input logic ewe);
        sb_t e;
        chk({name, ".gnt_rr"}, 32'(a_gnt), 32'(ega));
        chk({name, ".gnt_fp"}, 32'(b_gnt), 32'(egb));
        chk({name, ".rdy_rr"}, 32'(a_rdy), 32'(erdy));
        chk({name, ".rdy_fp"}, 32'(b_rdy), 32'(erdy));
        chk({name, ".ram_we"}, 32'(a_ram_we), 32'(ewe));
        if (ega != '0) chk({name, ".ram_addr"}, 32'(a_ram_addr), 32'(addr_of(ega)));
        if (sbq.size() > 0) begin
            e = sbq.pop_front();
            chk({name, ".valid"}, 32'(a_val), 32'(e.v));
            chk({name, ".rdata"}, 32'(a_rdata), 32'(e.d));
        end else begin
            chk({name, ".valid"}, 32'(a_val), 32'd0);
        end
        if (ega != '0) sbq.push_back('{v: ega, d: fdat(addr_of(ega))});
    endtask

    task automatic next_cyc();
        @(posedge clk);
        #1;
    endtask

    initial begin
        for (int i = 0; i < 2**AW; i++) begin
            mem_a[i] = fdat(AW'(i));
            mem_b[i] = fdat(AW'(i));
        end

        tbl[0]  = '{3'b111, 1'b0, 1'b0, 3'b000, 3'b000, 1'b1, 1'b0};
        tbl[1]  = '{3'b111, 1'b1, 1'b0, 3'b000, 3'b000, 1'b1, 1'b0};
        tbl[2]  = '{3'b111, 1'b1, 1'b0, 3'b010, 3'b001, 1'b0, 1'b0};
        tbl[3]  = '{3'b111, 1'b1, 1'b1, 3'b100, 3'b001, 1'b0, 1'b0};
        tbl[4]  = '{3'b111, 1'b1, 1'b0, 3'b001, 3'b001, 1'b0, 1'b0};
        tbl[5]  = '{3'b111, 1'b1, 1'b0, 3'b010, 3'b001, 1'b0, 1'b0};
        tbl[6]  = '{3'b111, 1'b1, 1'b0, 3'b000, 3'b000, 1'b1, 1'b0};
        tbl[7]  = '{3'b111, 1'b1, 1'b1, 3'b000, 3'b000, 1'b1, 1'b1};
        tbl[8]  = '{3'b111, 1'b0, 1'b0, 3'b000, 3'b000, 1'b1, 1'b0};
        tbl[9]  = '{3'b111, 1'b1, 1'b0, 3'b000, 3'b000, 1'b1, 1'b0};
        tbl[10] = '{3'b111, 1'b1, 1'b0, 3'b100, 3'b001, 1'b0, 1'b0};
        tbl[11] = '{3'b000, 1'b1, 1'b0, 3'b000, 3'b000, 1'b0, 1'b0};
        tbl[12] = '{3'b000, 1'b1, 1'b0, 3'b000, 3'b000, 1'b1, 1'b0};

        reset_n   = 1'b0;
        cpu_addr  = '0;
        cpu_wdata = '0;
        cpu_we    = 1'b1;
        cpu_sync  = 1'b0;
        cli_req   = '0;
        cli_addr  = {caddr(2), caddr(1), caddr(0)};

        // Reset state, with cpu_we held high to show it is blocked.
        repeat (2) @(negedge clk);
        check_cycle("reset", 3'b000, 3'b000, 1'b0, 1'b0);
        next_cyc();
        reset_n = 1'b1;
        cpu_we  = 1'b0;
        @(negedge clk);
        check_cycle("rst_wait", 3'b000, 3'b000, 1'b0, 1'b0);

        // CPU write then read-back.
        next_cyc();
        cpu_addr  = 11'h123;
        cpu_wdata = 8'h5A;
        cpu_we    = 1'b1;
        @(negedge clk);
        check_cycle("cpu_write", 3'b000, 3'b000, 1'b1, 1'b1);
        chk("cpu_write.addr", 32'(a_ram_addr), 32'h123);
        next_cyc();
        cpu_we = 1'b0;
        @(negedge clk);
        check_cycle("cpu_read", 3'b000, 3'b000, 1'b1, 1'b0);
        next_cyc();
        @(negedge clk);
        check_cycle("cpu_readback", 3'b000, 3'b000, 1'b1, 1'b0);
        chk("cpu_readback.rdata_rr", 32'(a_rdata), 32'h5A);
        chk("cpu_readback.rdata_fp", 32'(b_rdata), 32'h5A);

        // Single client request raised mid-instruction.
        next_cyc();
        cli_req  = 3'b001;
        cpu_sync = 1'b0;
        @(negedge clk);
        check_cycle("mid_instr0", 3'b000, 3'b000, 1'b1, 1'b0);
        next_cyc();
        @(negedge clk);
        check_cycle("mid_instr1", 3'b000, 3'b000, 1'b1, 1'b0);
        next_cyc();
        cpu_sync = 1'b1;
        @(negedge clk);
        check_cycle("sync_fetch", 3'b000, 3'b000, 1'b1, 1'b0);
        next_cyc();
        @(negedge clk);
        check_cycle("stall_gnt", 3'b001, 3'b001, 1'b0, 1'b0);
        next_cyc();
        cli_req = 3'b000;
        @(negedge clk);
        check_cycle("stall_valid", 3'b000, 3'b000, 1'b0, 1'b0);
        next_cyc();
        @(negedge clk);
        check_cycle("resume", 3'b000, 3'b000, 1'b1, 1'b0);

        // Bursts with all clients requesting, burst cap and hold rule.
        for (int r = 0; r < 13; r++) begin
            next_cyc();
            cli_req  = tbl[r].req;
            cpu_sync = tbl[r].sync;
            cpu_we   = tbl[r].we;
            @(negedge clk);
            check_cycle($sformatf("tbl%0d", r), tbl[r].ega, tbl[r].egb, tbl[r].erdy, tbl[r].ewe);
        end

        // Reset pulsed while a grant is outstanding and a valid is live.
        next_cyc();
        cpu_we   = 1'b0;
        cli_req  = 3'b001;
        cpu_sync = 1'b0;
        @(negedge clk);
        check_cycle("t4_clr", 3'b000, 3'b000, 1'b1, 1'b0);
        next_cyc();
        cpu_sync = 1'b1;
        @(negedge clk);
        check_cycle("t4_sync", 3'b000, 3'b000, 1'b1, 1'b0);
        next_cyc();
        @(negedge clk);
        check_cycle("t4_gnt0", 3'b001, 3'b001, 1'b0, 1'b0);
        next_cyc();
        @(negedge clk);
        check_cycle("t4_gnt1", 3'b001, 3'b001, 1'b0, 1'b0);
        #1;
        reset_n = 1'b0;
        #1;
        chk("t4_rst.gnt_rr", 32'(a_gnt), 32'd0);
        chk("t4_rst.gnt_fp", 32'(b_gnt), 32'd0);
        chk("t4_rst.valid_rr", 32'(a_val), 32'd0);
        chk("t4_rst.valid_fp", 32'(b_val), 32'd0);
        chk("t4_rst.rdy_rr", 32'(a_rdy), 32'd0);
        sbq.delete();
        next_cyc();
        chk("t4_rst.discard", 32'(a_val), 32'd0);
        reset_n = 1'b1;
        cli_req = 3'b111;
        @(negedge clk);
        check_cycle("t4_rst_wait", 3'b000, 3'b000, 1'b0, 1'b0);
        next_cyc();
        @(negedge clk);
        check_cycle("t4_run", 3'b000, 3'b000, 1'b1, 1'b0);
        next_cyc();
        @(negedge clk);
        check_cycle("t4_rr0", 3'b001, 3'b001, 1'b0, 1'b0);
        next_cyc();
        cli_req = 3'b000;
        @(negedge clk);
        check_cycle("t4_valid", 3'b000, 3'b000, 1'b0, 1'b0);
        next_cyc();
        @(negedge clk);
        check_cycle("t4_done", 3'b000, 3'b000, 1'b1, 1'b0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
